// File: rtl/cam_capture_rgb444_pkg.sv
// Shared constants, FSM encoding and RGB444 field layout for the camera capture block.
package cam_capture_rgb444_pkg;

   localparam int DEF_IMG_W   = 160;
   localparam int DEF_IMG_H   = 120;
   localparam int DEF_IMA_SIZ = DEF_IMG_W * DEF_IMG_H;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_FRAME = 2'd1,
      ST_BYTE_HI    = 2'd2,
      ST_BYTE_LO    = 2'd3
   } state_e;

   localparam int FIELD_W = 4;
   localparam int R_LSB   = 8;
   localparam int G_LSB   = 4;
   localparam int B_LSB   = 0;

   function automatic logic [11:0] pack_rgb444(input logic [3:0] r,
                                               input logic [3:0] g,
                                               input logic [3:0] b);
      logic [11:0] px;
      px = 12'h000;
      px[R_LSB +: FIELD_W] = r;
      px[G_LSB +: FIELD_W] = g;
      px[B_LSB +: FIELD_W] = b;
      return px;
   endfunction

endpackage

// File: rtl/cam_capture_rgb444_if.sv
// Camera byte bus plus frame-buffer write port; master drives the camera side, slave is the capture block.
interface cam_capture_rgb444_if
   import cam_capture_rgb444_pkg::*;
#(
   parameter int AW = 15,
   parameter int DW = 12
) ();

   logic          en;
   logic          vsync;
   logic          href;
   logic [7:0]    px_data;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_out;
   logic          regwrite;
   logic          frame_done;

   modport master (
      output en, vsync, href, px_data,
      input  addr, data_out, regwrite, frame_done
   );

   modport slave (
      input  en, vsync, href, px_data,
      output addr, data_out, regwrite, frame_done
   );

endinterface

// File: rtl/cam_capture_rgb444_edge_detect.sv
// Single-cycle rise/fall pulses for a level already synchronous to clk.
module cam_capture_rgb444_edge_detect
   import cam_capture_rgb444_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic sig,
   output logic rise,
   output logic fall
);

   logic sig_d_r;

   // previous sampled level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig_d_r <= 1'b0;
      end else begin
         sig_d_r <= sig;
      end
   end

   assign rise = sig & ~sig_d_r;
   assign fall = ~sig & sig_d_r;

endmodule

// File: rtl/cam_capture_rgb444.sv
// Assembles two camera bytes into one RGB444 pixel and writes it linearly into a frame buffer.
module cam_capture_rgb444
   import cam_capture_rgb444_pkg::*;
#(
   parameter int AW    = 15,
   parameter int DW    = 12,
   parameter int IMG_W = cam_capture_rgb444_pkg::DEF_IMG_W,
   parameter int IMG_H = cam_capture_rgb444_pkg::DEF_IMG_H
) (
   input  logic                 clk,
   input  logic                 rst,
   cam_capture_rgb444_if.slave  cam
);

   localparam int FRAME_PIX = IMG_W * IMG_H;
   localparam int CW        = $clog2(IMG_W + 1);
   localparam int LW        = $clog2(IMG_H + 1);

   localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIX - 1);
   localparam logic [CW-1:0] COL_LIM   = CW'(IMG_W);
   localparam logic [LW-1:0] LINE_LIM  = LW'(IMG_H);

   state_e        state_r;
   logic [3:0]    red_r;
   logic [CW-1:0] col_r;
   logic [LW-1:0] line_r;

   logic vsync_rise_s;
   logic vsync_fall_s;
   logic href_rise_s;
   logic href_fall_s;
   logic wr_ok_s;

   cam_capture_rgb444_edge_detect u_vsync_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (cam.vsync),
      .rise (vsync_rise_s),
      .fall (vsync_fall_s)
   );

   cam_capture_rgb444_edge_detect u_href_edge (
      .clk  (clk),
      .rst  (rst),
      .sig  (cam.href),
      .rise (href_rise_s),
      .fall (href_fall_s)
   );

   // Overlong lines or extra lines never spill past the frame; address IMG_W*IMG_H stays unwritten.
   assign wr_ok_s = (cam.addr <= LAST_ADDR) && (col_r < COL_LIM) && (line_r < LINE_LIM);

   // capture FSM driving the registered frame-buffer write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         red_r          <= 4'h0;
         col_r          <= {CW{1'b0}};
         line_r         <= {LW{1'b0}};
         cam.addr       <= {AW{1'b0}};
         cam.data_out   <= {DW{1'b0}};
         cam.regwrite   <= 1'b0;
         cam.frame_done <= 1'b0;
      end else begin
         cam.regwrite   <= 1'b0;
         cam.frame_done <= 1'b0;
         if (cam.regwrite) begin
            cam.addr <= cam.addr + AW'(1);
         end
         if (!cam.en) begin
            state_r <= ST_IDLE;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  state_r <= ST_WAIT_FRAME;
               end
               ST_WAIT_FRAME: begin
                  if (vsync_fall_s) begin
                     cam.addr <= {AW{1'b0}};
                     col_r    <= {CW{1'b0}};
                     line_r   <= {LW{1'b0}};
                     red_r    <= 4'h0;
                     state_r  <= ST_BYTE_HI;
                  end
               end
               ST_BYTE_HI, ST_BYTE_LO: begin
                  if (vsync_rise_s) begin
                     state_r <= ST_WAIT_FRAME;
                  end else if (cam.regwrite && (cam.addr == LAST_ADDR)) begin
                     cam.frame_done <= 1'b1;
                     state_r        <= ST_WAIT_FRAME;
                  end else if (!cam.href) begin
                     state_r <= ST_BYTE_HI;
                     if (href_fall_s) begin
                        col_r <= {CW{1'b0}};
                        if (line_r != LINE_LIM) begin
                           line_r <= line_r + LW'(1);
                        end
                     end
                  end else if (state_r == ST_BYTE_HI) begin
                     red_r   <= cam.px_data[3:0];
                     state_r <= ST_BYTE_LO;
                     if (href_rise_s) begin
                        col_r <= {CW{1'b0}};
                     end
                  end else begin
                     if (wr_ok_s) begin
                        cam.data_out <= DW'(pack_rgb444(red_r, cam.px_data[7:4], cam.px_data[3:0]));
                        cam.regwrite <= 1'b1;
                        col_r        <= col_r + CW'(1);
                     end
                     state_r <= ST_BYTE_HI;
                  end
               end
               default: begin
                  state_r <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Directed bench: a pixel-level model predicts every write and frame_done pulse with its cycle.
module tb_cam_capture_rgb444;

   localparam int AW    = 15;
   localparam int DW    = 12;
   localparam int IMG_W = 160;
   localparam int IMG_H = 120;
   localparam int FRAME = IMG_W * IMG_H;

   logic clk = 1'b0;
   logic rst;

   cam_capture_rgb444_if #(.AW(AW), .DW(DW)) cam_if ();

   cam_capture_rgb444 #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
      .clk (clk),
      .rst (rst),
      .cam (cam_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int due;
      int addr;
      int data;
   } wr_t;

   wr_t  exp_wr[$];
   int   exp_fd[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   wr_count = 0;
   int   fd_count = 0;
   int   last_addr = -1;
   int   last_data = -1;
   int   hi_addr_hits = 0;

   bit   in_frame = 1'b0;
   int   exp_addr = 0;
   int   line_idx = 0;
   logic vs_level = 1'b0;
   logic [7:0] line_bytes[$];
   logic [7:0] bval;
   int   w0;
   int   fd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
      end
   endtask

   task automatic drive(input logic v, input logic h, input logic [7:0] d);
      @(posedge clk);
      #1;
      cam_if.vsync   = v;
      cam_if.href    = h;
      cam_if.px_data = d;
   endtask

   task automatic frame_start();
      vs_level = 1'b1;
      repeat (3) drive(1'b1, 1'b0, 8'h00);
      vs_level = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      if (cam_if.en) begin
         in_frame = 1'b1;
         exp_addr = 0;
         line_idx = 0;
      end
      repeat (2) drive(1'b0, 1'b0, 8'h00);
   endtask

   // drop_at: byte index at which en is pulled low (-1 keeps en high)
   task automatic send_line(input int drop_at);
      wr_t e;
      for (int i = 0; i < line_bytes.size(); i++) begin
         drive(vs_level, 1'b1, line_bytes[i]);
         if (i == drop_at) begin
            cam_if.en = 1'b0;
            in_frame  = 1'b0;
         end
         if ((i % 2 == 1) && in_frame && (line_idx < IMG_H) && ((i / 2) < IMG_W) && (exp_addr < FRAME)) begin
            e.due  = cyc + 1;
            e.addr = exp_addr;
            e.data = int'({line_bytes[i-1][3:0], line_bytes[i]});
            exp_wr.push_back(e);
            if (exp_addr == FRAME - 1) begin
               exp_fd.push_back(e.due + 1);
               in_frame = 1'b0;
            end
            exp_addr++;
         end
      end
      repeat (3) drive(vs_level, 1'b0, 8'h00);
      line_idx++;
   endtask

   task automatic fill_line(input int n);
      line_bytes.delete();
      for (int i = 0; i < n; i++) begin
         line_bytes.push_back(bval);
         bval = bval + 8'd1;
      end
   endtask

   // output monitor, compares against the model queues every falling edge
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (cam_if.regwrite) begin
               wr_count++;
               last_addr = int'(cam_if.addr);
               last_data = int'(cam_if.data_out);
               if (last_addr >= FRAME) hi_addr_hits++;
               chk("write_expected", (exp_wr.size() > 0) ? 1 : 0, 1);
               if (exp_wr.size() > 0) begin
                  e = exp_wr.pop_front();
                  chk("wr_cycle", cyc, e.due);
                  chk("wr_addr", last_addr, e.addr);
                  chk("wr_data", last_data, e.data);
               end
            end
            if (exp_wr.size() > 0 && exp_wr[0].due < cyc) begin
               chk("write_missed_due", exp_wr[0].due, cyc);
               void'(exp_wr.pop_front());
            end
            if (cam_if.frame_done) begin
               fd_count++;
               chk("frame_done_expected", (exp_fd.size() > 0) ? 1 : 0, 1);
               if (exp_fd.size() > 0) begin
                  chk("frame_done_cycle", cyc, exp_fd.pop_front());
               end
            end
            if (exp_fd.size() > 0 && exp_fd[0] < cyc) begin
               chk("frame_done_missed_due", exp_fd[0], cyc);
               void'(exp_fd.pop_front());
            end
         end
      end
   end

   initial begin
      rst            = 1'b0;
      cam_if.en      = 1'b0;
      cam_if.vsync   = 1'b1;
      cam_if.href    = 1'b0;
      cam_if.px_data = 8'h00;
      #3;
      chk("reset_addr", int'(cam_if.addr), 0);
      chk("reset_data", int'(cam_if.data_out), 0);
      chk("reset_regwrite", int'(cam_if.regwrite), 0);
      chk("reset_frame_done", int'(cam_if.frame_done), 0);
      repeat (3) @(posedge clk);
      #1;
      rst       = 1'b1;
      cam_if.en = 1'b1;

      // single pixel 0x0A,0x5C
      w0 = wr_count;
      frame_start();
      line_bytes = '{8'h0A, 8'h5C};
      send_line(-1);
      chk("single_count", wr_count - w0, 1);
      chk("single_addr", last_addr, 0);
      chk("single_data", last_data, 12'hA5C);

      // odd byte count then a fresh pair on the next line
      line_bytes = '{8'h11, 8'h22, 8'h33};
      send_line(-1);
      chk("odd_addr", last_addr, 1);
      chk("odd_data", last_data, 12'h122);
      line_bytes = '{8'h12, 8'h34};
      send_line(-1);
      chk("after_odd_addr", last_addr, 2);
      chk("after_odd_data", last_data, 12'h234);

      // asynchronous reset while a write strobe is due
      w0 = wr_count;
      drive(1'b0, 1'b1, 8'h3C);
      drive(1'b0, 1'b1, 8'hD2);
      @(posedge clk);
      #2;
      rst      = 1'b0;
      in_frame = 1'b0;
      #1;
      chk("midreset_addr", int'(cam_if.addr), 0);
      chk("midreset_data", int'(cam_if.data_out), 0);
      chk("midreset_regwrite", int'(cam_if.regwrite), 0);
      chk("midreset_frame_done", int'(cam_if.frame_done), 0);
      cam_if.href = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      line_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_line(-1);
      chk("post_reset_writes", wr_count - w0, 0);

      // full frame of incrementing bytes
      w0   = wr_count;
      fd0  = fd_count;
      bval = 8'h00;
      frame_start();
      for (int l = 0; l < IMG_H; l++) begin
         fill_line(2 * IMG_W);
         send_line(-1);
      end
      chk("frame_writes", wr_count - w0, 19200);
      chk("frame_last_addr", last_addr, 19199);
      chk("frame_last_data", last_data, 12'hEFF);
      chk("frame_done_count", fd_count - fd0, 1);
      chk("reserved_addr_hits", hi_addr_hits, 0);
      w0 = wr_count;
      fill_line(4);
      send_line(-1);
      chk("post_frame_writes", wr_count - w0, 0);

      // vsync rise after line 10 aborts the frame
      w0  = wr_count;
      fd0 = fd_count;
      frame_start();
      for (int l = 0; l < 10; l++) begin
         fill_line(4);
         send_line(-1);
      end
      vs_level = 1'b1;
      drive(1'b1, 1'b0, 8'h00);
      in_frame = 1'b0;
      fill_line(4);
      send_line(-1);
      chk("abort_writes", wr_count - w0, 20);
      frame_start();
      line_bytes = '{8'h0F, 8'h7E};
      send_line(-1);
      chk("restart_addr", last_addr, 0);
      chk("restart_data", last_data, 12'hF7E);
      chk("abort_frame_done", fd_count - fd0, 0);

      // en dropped during line 5
      w0 = wr_count;
      frame_start();
      for (int l = 0; l < 4; l++) begin
         fill_line(4);
         send_line(-1);
      end
      fill_line(8);
      send_line(3);
      chk("disable_writes", wr_count - w0, 9);
      repeat (2) drive(1'b0, 1'b0, 8'h00);
      cam_if.en = 1'b1;
      w0 = wr_count;
      fill_line(4);
      send_line(-1);
      chk("reenable_no_vsync_writes", wr_count - w0, 0);

      repeat (4) @(posedge clk);
      #1;
      chk("pending_writes_left", exp_wr.size(), 0);
      chk("pending_frame_done_left", exp_fd.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cam_capture_rgb444.md
CAM_CAPTURE_RGB444 -- requirements
Module: cam_capture_rgb444

Interface
REQ-001 Parameter AW, default 15, write-address width in bits.
REQ-002 Parameter DW, default 12, pixel width in bits (RGB444).
REQ-003 Parameter IMG_W, default 160, pixels per line.
REQ-004 Parameter IMG_H, default 120, lines per frame.
REQ-005 Port clk  input  1  camera pixel clock (PCLK); the only clock; all logic on rising edge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port en  input  1  capture enable; high once camera register init is complete.
REQ-008 Port vsync  input  1  camera frame sync; high between frames.
REQ-009 Port href  input  1  camera line valid; high while bytes of a line are valid.
REQ-010 Port px_data  input  8  camera byte bus.
REQ-011 Port addr  output  AW  frame-buffer write address.
REQ-012 Port data_out  output  DW  assembled pixel {R,G,B}, 4 bits each.
REQ-013 Port regwrite  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-014 Port frame_done  output  1  one-cycle pulse after the last pixel of a complete frame.

Function
REQ-015 FSM states: IDLE, WAIT_FRAME, BYTE_HI, BYTE_LO; all registered outputs.
REQ-016 IDLE -> WAIT_FRAME when en=1; any state -> IDLE when en=0, with regwrite=0 from the next cycle.
REQ-017 WAIT_FRAME -> BYTE_HI on a sampled vsync 1->0 edge; addr and pixel counters reset to 0 on that edge.
REQ-018 In BYTE_HI with href=1: latch px_data[3:0] as R; go to BYTE_LO.
REQ-019 In BYTE_LO with href=1: drive data_out={R_latched, px_data[7:4], px_data[3:0]} and regwrite=1 on the next cycle; go to BYTE_HI.
REQ-020 Write latency: data_out/regwrite valid exactly 1 clk after the second byte is sampled; addr holds that pixel's address during the strobe.
REQ-021 addr increments by 1 the cycle after each regwrite pulse.
REQ-022 href=0 in either byte state returns the byte phase to BYTE_HI; a dangling first byte is discarded, no write.
REQ-023 Addresses written are 0..IMG_W*IMG_H-1 only; writes beyond the last pixel are suppressed (address IMG_W*IMG_H is reserved black, never written).
REQ-024 Line counter increments on each href 1->0 edge; column counter clears there.
REQ-025 frame_done pulses 1 clk after the write to address IMG_W*IMG_H-1; FSM then returns to WAIT_FRAME.
REQ-026 vsync rising mid-frame aborts the frame: no frame_done, FSM -> WAIT_FRAME, addr unchanged until next vsync fall.
REQ-027 vsync falling and href rising in the same cycle: counters reset takes priority, first byte captured the following cycle.

Reset
REQ-028 rst=0 forces asynchronously: state IDLE, addr=0, data_out=0, regwrite=0, frame_done=0, all counters and latched R=0.
REQ-029 Deassertion mid-frame: FSM waits for a fresh vsync fall before writing.

Structure
REQ-030 Shared package holds IMG_W, IMG_H, IMA_SIZ=IMG_W*IMG_H, FSM state encoding, RGB444 field positions.
REQ-031 Sub-module edge_detect (rise/fall pulse generator) instantiated for vsync and href.
REQ-032 Output pins directly drive buffer_ram_dp port 1 (clk_w=clk, addr_in, data_in, regwrite).

Verification
REQ-033 Reset: rst=0 mid-stream -> all outputs 0 within same cycle; no writes until next vsync fall.
REQ-034 Single pixel: en=1, vsync 1->0, href=1, bytes 0x0A,0x5C -> one regwrite, addr=0, data_out=12'hA5C, 1 clk after byte 2.
REQ-035 Full frame: 120 lines x 320 bytes incrementing -> 19200 writes, last addr=19199, frame_done one pulse, addr 19200 never written.
REQ-036 Odd byte count: href drops after 3 bytes -> exactly 1 write, next line starts at BYTE_HI.
REQ-037 Abort: vsync rises after line 10 -> no frame_done; next frame restarts at addr=0.
REQ-038 Disable: en=0 during line 5 -> regwrite=0 from next cycle, FSM IDLE.
